// File: rtl/uart_loopback_queue.sv
// Buffered receiver-to-transmitter echo stage: FIFO capture on rx_ready rising edge plus dispatch FSM.
// Optional LOOPBACK_CRLF_EN: append 0x0A after every transmitted 0x0D.
module uart_loopback_queue #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rx_ready,
    input  logic [DATA_W-1:0] i_rx_data,
    input  logic              i_tx_ready,
    output logic              o_tx_start,
    output logic [DATA_W-1:0] o_tx_data,
    output logic [ADDR_W:0]   o_fifo_count,
    output logic              o_fifo_empty,
    output logic              o_fifo_full,
    output logic              o_overflow
);

`ifdef LOOPBACK_CRLF_EN
    typedef enum logic [1:0] {StIdle, StStart, StBusy, StLf} state_e;
    localparam logic [DATA_W-1:0] CharCr = DATA_W'(8'h0D);
    localparam logic [DATA_W-1:0] CharLf = DATA_W'(8'h0A);
`else
    typedef enum logic [1:0] {StIdle, StStart, StBusy} state_e;
`endif

    localparam logic [ADDR_W-1:0] PtrOne    = 1;
    localparam logic [ADDR_W:0]   CountOne  = 1;
    localparam logic [ADDR_W:0]   CountFull = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_empty;
    logic              r_full;
    logic              r_overflow;
    logic              r_rx_ready_d;
    state_e            r_state;
    logic              r_tx_start;
    logic [DATA_W-1:0] r_tx_data;

    logic              w_push;
    logic              w_pop;
    logic              w_wr_en;
    logic              w_drop;
    logic [ADDR_W:0]   w_count_d;
    state_e            w_state_d;
    logic              w_tx_start_d;
    logic [DATA_W-1:0] w_tx_data_d;

    assign w_push  = i_rx_ready & ~r_rx_ready_d;
    // A push into a full FIFO still succeeds when the dispatcher frees a slot on the same edge.
    assign w_wr_en = w_push & (~r_full | w_pop);
    assign w_drop  = w_push & r_full & ~w_pop;

    always_comb begin
        w_count_d = r_count;
        unique case ({w_wr_en, w_pop})
            2'b10:   w_count_d = r_count + CountOne;
            2'b01:   w_count_d = r_count - CountOne;
            default: w_count_d = r_count;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_rx_ready_d <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_empty      <= 1'b1;
            r_full       <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_rx_ready_d <= i_rx_ready;
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PtrOne;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrOne;
            end
            r_count <= w_count_d;
            r_empty <= (w_count_d == '0);
            r_full  <= (w_count_d == CountFull);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge i_clk) begin
        if (i_rst && w_wr_en) begin
            r_mem[r_wr_ptr] <= i_rx_data;
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_tx_start_d = r_tx_start;
        w_tx_data_d  = r_tx_data;
        w_pop        = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_tx_start_d = 1'b0;
                if (!r_empty && i_tx_ready) begin
                    w_pop        = 1'b1;
                    w_tx_data_d  = r_mem[r_rd_ptr];
                    w_tx_start_d = 1'b1;
                    w_state_d    = StStart;
                end
            end
            StStart: begin
                w_tx_start_d = 1'b1;
                if (!i_tx_ready) begin
                    w_tx_start_d = 1'b0;
                    w_state_d    = StBusy;
                end
            end
            StBusy: begin
                w_tx_start_d = 1'b0;
                if (i_tx_ready) begin
`ifdef LOOPBACK_CRLF_EN
                    w_state_d = (r_tx_data == CharCr) ? StLf : StIdle;
`else
                    w_state_d = StIdle;
`endif
                end
            end
`ifdef LOOPBACK_CRLF_EN
            // Inserted line feed; no FIFO entry is consumed.
            StLf: begin
                w_tx_start_d = 1'b0;
                if (i_tx_ready) begin
                    w_tx_data_d  = CharLf;
                    w_tx_start_d = 1'b1;
                    w_state_d    = StStart;
                end
            end
`endif
            default: begin
                w_tx_start_d = 1'b0;
                w_state_d    = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state    <= StIdle;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            r_state    <= w_state_d;
            r_tx_start <= w_tx_start_d;
            r_tx_data  <= w_tx_data_d;
        end
    end

    assign o_tx_start   = r_tx_start;
    assign o_tx_data    = r_tx_data;
    assign o_fifo_count = r_count;
    assign o_fifo_empty = r_empty;
    assign o_fifo_full  = r_full;
    assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_uart_loopback_queue.sv
// Directed self-checking bench for uart_loopback_queue; honours LOOPBACK_CRLF_EN when defined.
module tb_uart_loopback_queue;

    logic       clk;
    logic       rst;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       tx_ready;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [4:0] fifo_count;
    logic       fifo_empty;
    logic       fifo_full;
    logic       overflow;

    int n_checks;
    int n_fails;

    uart_loopback_queue #(
        .DEPTH  (16),
        .ADDR_W (4),
        .DATA_W (8)
    ) u_dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_rx_ready   (rx_ready),
        .i_rx_data    (rx_data),
        .i_tx_ready   (tx_ready),
        .o_tx_start   (tx_start),
        .o_tx_data    (tx_data),
        .o_fifo_count (fifo_count),
        .o_fifo_empty (fifo_empty),
        .o_fifo_full  (fifo_full),
        .o_overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs/samples happen 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        tick();
    endtask

    // Transmitter model: wait for a start, check the byte, accept it, then go idle again.
    task automatic xmit(input string tag, input logic [7:0] exp);
        int waited;
        waited = 0;
        while (!tx_start && waited < 40) begin
            tick();
            waited++;
        end
        if (!tx_start) begin
            check_eq({tag, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        check_eq({tag, "_data"}, tx_data, exp);
        tx_ready = 1'b0;
        tick();
        check_eq({tag, "_start_fall"}, tx_start, 1'b0);
        tick();
        tx_ready = 1'b1;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst      = 1'b0;
        rx_ready = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b1;

        // Reset held 3 clocks while rx_ready toggles
        for (int i = 0; i < 3; i++) begin
            rx_ready = ~rx_ready;
            rx_data  = 8'h55;
            tick();
        end
        check_eq("rst_tx_start", tx_start, 1'b0);
        check_eq("rst_tx_data", tx_data, 8'h00);
        check_eq("rst_count", fifo_count, 5'd0);
        check_eq("rst_empty", fifo_empty, 1'b1);
        check_eq("rst_full", fifo_full, 1'b0);
        check_eq("rst_overflow", overflow, 1'b0);
        rx_ready = 1'b0;
        rst      = 1'b1;
        tick();
        tick();
        check_eq("idle_count", fifo_count, 5'd0);
        check_eq("idle_tx_start", tx_start, 1'b0);

        // Single byte, rx_ready held 5 clocks, exact latency
        rx_data  = 8'h41;
        rx_ready = 1'b1;
        tick();
        check_eq("single_count_e1", fifo_count, 5'd1);
        check_eq("single_start_e1", tx_start, 1'b0);
        tick();
        check_eq("single_start_e2", tx_start, 1'b1);
        check_eq("single_data_e2", tx_data, 8'h41);
        check_eq("single_count_e2", fifo_count, 5'd0);
        tick();
        tick();
        tick();
        check_eq("single_one_push", fifo_count, 5'd0);
        check_eq("single_start_hold", tx_start, 1'b1);
        rx_ready = 1'b0;
        tx_ready = 1'b0;
        tick();
        check_eq("single_start_fall", tx_start, 1'b0);
        check_eq("single_data_hold", tx_data, 8'h41);
        tx_ready = 1'b1;
        tick();
        tick();
        check_eq("single_empty", fifo_empty, 1'b1);
        check_eq("single_no_resend", tx_start, 1'b0);

        // Burst while transmitter busy
        tx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) push_byte(8'(i));
        check_eq("burst_count", fifo_count, 5'd5);
        check_eq("burst_empty", fifo_empty, 1'b0);
        tx_ready = 1'b1;
        for (int i = 1; i <= 5; i++) xmit("burst", 8'(i));
        tick();
        check_eq("burst_drained", fifo_empty, 1'b1);
        check_eq("burst_no_extra", tx_start, 1'b0);

        // Overflow: 17 pushes, last one dropped
        tx_ready = 1'b0;
        for (int i = 0; i <= 16; i++) begin
            push_byte(8'(i));
            if (i == 15) check_eq("ovf_not_yet", overflow, 1'b0);
        end
        check_eq("ovf_count", fifo_count, 5'd16);
        check_eq("ovf_full", fifo_full, 1'b1);
        check_eq("ovf_flag", overflow, 1'b1);
        tx_ready = 1'b1;
        for (int i = 0; i <= 15; i++) xmit("ovf_drain", 8'(i));
        tick();
        check_eq("ovf_drain_empty", fifo_empty, 1'b1);
        check_eq("ovf_sticky", overflow, 1'b1);

        // Pointer wrap with transmitter ready
        for (int i = 0; i < 20; i++) begin
            push_byte(8'(8'h80 + i));
            xmit("wrap", 8'(8'h80 + i));
        end
        tick();
        check_eq("wrap_empty", fifo_empty, 1'b1);

        // Simultaneous push and pop while full
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) push_byte(8'(8'h20 + i));
        check_eq("sim_full", fifo_full, 1'b1);
        rx_data  = 8'h30;
        rx_ready = 1'b1;
        tx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        check_eq("sim_count", fifo_count, 5'd16);
        check_eq("sim_overflow", overflow, 1'b0);
        check_eq("sim_start", tx_start, 1'b1);
        for (int i = 0; i < 16; i++) xmit("sim_drain", 8'(8'h20 + i));
        xmit("sim_last", 8'h30);
        tick();
        check_eq("sim_empty", fifo_empty, 1'b1);
        check_eq("sim_overflow_end", overflow, 1'b0);

        // Reset while BUSY with 3 bytes queued
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_byte(8'(8'h50 + i));
        tx_ready = 1'b1;
        tick();
        check_eq("rmid_start", tx_start, 1'b1);
        tx_ready = 1'b0;
        tick();
        check_eq("rmid_busy", tx_start, 1'b0);
        check_eq("rmid_queued", fifo_count, 5'd3);
        rst = 1'b0;
        tick();
        check_eq("rmid_tx_start", tx_start, 1'b0);
        check_eq("rmid_count", fifo_count, 5'd0);
        check_eq("rmid_empty", fifo_empty, 1'b1);
        check_eq("rmid_data", tx_data, 8'h00);
        rst      = 1'b1;
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check_eq("rmid_discarded", tx_start, 1'b0);

        // CR handling: with the feature, 0x0D is followed by an inserted 0x0A
        tx_ready = 1'b0;
        push_byte(8'h0D);
        push_byte(8'h0E);
        check_eq("cr_count", fifo_count, 5'd2);
        tx_ready = 1'b1;
        xmit("cr_byte", 8'h0D);
        check_eq("cr_count_after", fifo_count, 5'd1);
`ifdef LOOPBACK_CRLF_EN
        xmit("cr_lf", 8'h0A);
        check_eq("cr_lf_count", fifo_count, 5'd1);
`endif
        xmit("cr_next", 8'h0E);
        tick();
        tick();
        check_eq("cr_empty", fifo_empty, 1'b1);
        check_eq("cr_quiet", tx_start, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
